prio_arbiter8: RTL
==================

# prio_arbiter8

Eight-way request arbiter that shares one resource among eight requesters. It extends the board's combinational priority-encode path into a sequenced grant controller. It issues a registered one-hot grant selected by either fixed priority or round-robin, and enforces a maximum hold time. The granted index drives the shared `bcd7seg` decoder, so the current owner appears on HEX0.

## Interface
- `MAX_HOLD`, default 15: maximum consecutive cycles one grant may last. Legal range 1..255; the hold counter is 8 bits.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: arbitration enable.
- `mode`  in  1: selection policy. 0 = fixed priority, highest index wins. 1 = round-robin.
- `req`  in  8: request lines, level-sensitive; bit i belongs to requester i.
- `gnt`  out  8: registered one-hot grant, or all zeros.
- `gnt_idx`  out  3: registered binary index of the current or last grant.
- `busy`  out  1: registered; 1 whenever `gnt` is nonzero.
- `HEX0`  out  7: active-low seven-segment pattern. Shows `gnt_idx` as a digit 0..7 via `bcd7seg({1'b0,gnt_idx})` when `busy`=1. Forced to 7'b1111111 (blank) when `busy`=0.

## Operation
- Registered state:
  - `state` ∈ {IDLE, GRANT}
  - `gnt`, `gnt_idx`
  - `ptr`: 3-bit index of the last winner
  - `hold_cnt`: 8 bits
- Reset values: state=IDLE, gnt=0, gnt_idx=0, busy=0, ptr=7, hold_cnt=0, HEX0=7'b1111111. Reset overrides all other inputs, including mid-grant.
- Winner selection, combinational from `req` and the candidate mask:
  - mode=0: highest set index.
  - mode=1: first set index scanning ptr+1, ptr+2, … with wrap-around modulo 8. The holder is scanned last.
- Candidate mask:
  - In IDLE: all of `req`.
  - On a forced release in GRANT: `req` with the holder's bit cleared, if any other bit is set. Otherwise `req` unmasked, so a sole requester is re-granted.
- Every new grant, including a re-grant, loads gnt=onehot(winner), gnt_idx=winner, ptr=winner, hold_cnt=0.
- IDLE transitions:
  - en=1 and req≠0: grant the winner, go to GRANT.
  - Otherwise: stay in IDLE, gnt=0.
- GRANT transitions, evaluated in priority order:
  1. en=0: gnt←0, go to IDLE. gnt_idx and ptr are retained.
  2. req[gnt_idx]=0 (voluntary release): if any other req bit is set, grant the winner directly with no idle bubble. Otherwise gnt←0, go to IDLE.
  3. hold_cnt=MAX_HOLD−1 (forced release): grant the winner over the masked candidate set.
  4. Otherwise: hold the grant, hold_cnt←hold_cnt+1.
- Mode changes take effect at the next selection point only. An active grant is never switched because `mode` toggled.
- `gnt` is never multi-hot. `busy` equals OR-reduce of `gnt` at all times.

## Timing
- Request-to-grant latency is 1 cycle: req sampled at edge k, gnt visible after edge k.
- Release-to-regrant latency is 1 cycle, with no gap cycle when other requests are pending.
- A grant lasts at most MAX_HOLD consecutive cycles before forced re-arbitration.
  - A sole continuous requester keeps `gnt` high without a gap; only hold_cnt restarts.
- A requester dropping req at edge k loses gnt after edge k.
- en=0 clears gnt after the next edge.
- HEX0 is combinational from registered outputs, so it is glitch-free relative to the clock.

## Test plan
- Reset: rst=1 for 2 cycles with req=8'hFF, en=1 → gnt=0, busy=0, gnt_idx=0, HEX0=7'b1111111. Release rst → gnt=8'h01 after the next edge, because mode=1 and ptr=7 make index 0 the first scanned.
- Fixed priority: mode=0, req=8'b0010_0110 → after 1 edge gnt=8'b0010_0000, gnt_idx=5, HEX0=bcd7seg(5). Holder drops bit 5 → next grant is index 2.
- Round-robin rotation: mode=1, MAX_HOLD=4, req=8'hFF held → gnt_idx sequence 0,1,…,7,0, each held exactly 4 cycles, busy never drops.
- Sole requester preemption: MAX_HOLD=4, req=8'h08 constant → gnt=8'h08 continuously for 20 cycles. hold_cnt wraps 0..3 repeatedly.
- Voluntary release: mode=1, req=8'h81, grant index 0, then deassert req[0] after 2 cycles → next edge gnt=8'h80. Then drop req=0 → IDLE, HEX0 blank.
- Enable/reset mid-grant: during an active grant drive en=0 → gnt=0 after 1 edge, gnt_idx retained. Restore en, then assert rst mid-grant → all outputs at reset values after that edge.

Source files
------------

// File: rtl/prio_arbiter8_if.sv
// rtl/prio_arbiter8_if.sv - request/grant bundle between requesters and the arbiter
interface prio_arbiter8_if;
  logic       en;
  logic       mode;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic [6:0] HEX0;

  modport master (
    output en, mode, req,
    input  gnt, gnt_idx, busy, HEX0
  );

  modport slave (
    input  en, mode, req,
    output gnt, gnt_idx, busy, HEX0
  );
endinterface

// File: rtl/prio_arbiter8.sv
// rtl/prio_arbiter8.sv - eight-way grant controller, fixed-priority or round-robin with hold limit
module prio_arbiter8 #(
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            rst,
  prio_arbiter8_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_n;
  logic [7:0] gnt_q, gnt_n;
  logic [2:0] idx_q, idx_n;
  logic [2:0] ptr_q, ptr_n;
  logic [7:0] hold_q, hold_n;
  logic       busy_q;

  logic [7:0] others;
  logic [7:0] cand;
  logic [2:0] win;
  logic       found;
  logic [2:0] scan;

  function automatic logic [6:0] bcd7seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd7seg = 7'b1000000;
      4'd1:    bcd7seg = 7'b1111001;
      4'd2:    bcd7seg = 7'b0100100;
      4'd3:    bcd7seg = 7'b0110000;
      4'd4:    bcd7seg = 7'b0011001;
      4'd5:    bcd7seg = 7'b0010010;
      4'd6:    bcd7seg = 7'b0000010;
      4'd7:    bcd7seg = 7'b1111000;
      4'd8:    bcd7seg = 7'b0000000;
      4'd9:    bcd7seg = 7'b0010000;
      default: bcd7seg = 7'b1111111;
    endcase
  endfunction

  // Forced release excludes the holder only when someone else is waiting.
  always_comb begin
    others = bus.req & ~gnt_q;
    cand   = bus.req;
    if (state_q == GRANT && others != 8'd0)
      cand = others;
  end

  always_comb begin
    win   = 3'd0;
    found = 1'b0;
    scan  = 3'd0;
    if (!bus.mode) begin
      for (int i = 0; i < 8; i++) begin
        if (cand[i]) begin
          win   = 3'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= 8; k++) begin
        scan = ptr_q + 3'(k);
        if (!found && cand[scan]) begin
          win   = scan;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_n = state_q;
    gnt_n   = gnt_q;
    idx_n   = idx_q;
    ptr_n   = ptr_q;
    hold_n  = hold_q;
    case (state_q)
      IDLE: begin
        gnt_n = 8'd0;
        if (bus.en && bus.req != 8'd0 && found) begin
          state_n = GRANT;
          gnt_n   = 8'd1 << win;
          idx_n   = win;
          ptr_n   = win;
          hold_n  = 8'd0;
        end
      end
      GRANT: begin
        if (!bus.en) begin
          state_n = IDLE;
          gnt_n   = 8'd0;
        end else if (!bus.req[idx_q] || hold_q == HOLD_LAST) begin
          if (bus.req != 8'd0 && found) begin
            gnt_n  = 8'd1 << win;
            idx_n  = win;
            ptr_n  = win;
            hold_n = 8'd0;
          end else begin
            state_n = IDLE;
            gnt_n   = 8'd0;
          end
        end else begin
          hold_n = hold_q + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      ptr_q   <= 3'd7;
      hold_q  <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      idx_q   <= idx_n;
      ptr_q   <= ptr_n;
      hold_q  <= hold_n;
      busy_q  <= |gnt_n;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.busy    = busy_q;
  assign bus.HEX0    = busy_q ? bcd7seg({1'b0, idx_q}) : 7'b1111111;

endmodule
